// File: rtl/menu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : menu_pkg
// Purpose  : Shared level-select menu geometry, FSM states and level ids.
// Revision : 1.0 - initial release
// ============================================================================
package menu_pkg;

  localparam logic [9:0] BTN_X0 = 10'd160;
  localparam logic [9:0] BTN_X1 = 10'd480;
  localparam logic [9:0] BTN_H  = 10'd60;
  localparam logic [3:1][9:0] BTN_Y0 = {10'd320, 10'd200, 10'd80};

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_1    = 2'd1;
  localparam logic [1:0] LVL_2    = 2'd2;
  localparam logic [1:0] LVL_3    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_READY = 3'd2,
    ST_PRESS = 3'd3,
    ST_REQ   = 3'd4
  } menu_state_t;

  // Inclusive lower, exclusive upper bound on both axes.
  function automatic logic in_button(input logic [9:0] x, input logic [9:0] y,
                                     input logic [1:0] k);
    return (x >= BTN_X0) && (x < BTN_X1) &&
           (y >= BTN_Y0[k]) && (y < BTN_Y0[k] + BTN_H);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer plus stability counter for a mouse button,
//            with one-cycle rise/fall pulses aligned to the debounced level.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_btn_db,
  output logic o_btn_rise,
  output logic o_btn_fall
);

  localparam logic [DB_W-1:0] C_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic [DB_W-1:0] r_cnt;
  logic            r_btn_db;
  logic            r_btn_rise;
  logic            r_btn_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= 2'b00;
      r_cnt      <= '0;
      r_btn_db   <= 1'b0;
      r_btn_rise <= 1'b0;
      r_btn_fall <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], i_btn_raw};
      r_btn_rise <= 1'b0;
      r_btn_fall <= 1'b0;
      if (r_sync[1] == r_btn_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        // Nth consecutive differing sample: commit the new level.
        r_cnt      <= '0;
        r_btn_db   <= ~r_btn_db;
        r_btn_rise <= ~r_btn_db;
        r_btn_fall <= r_btn_db;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_btn_db   = r_btn_db;
  assign o_btn_rise = r_btn_rise;
  assign o_btn_fall = r_btn_fall;

endmodule
`default_nettype wire

// File: rtl/menu_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : menu_input_ctrl
// Purpose  : Mouse hover flags and click-to-level-select request for the menu.
//            Optional level locking is enabled by defining MENU_LEVEL_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module menu_input_ctrl
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_menu,
  input  logic [9:0] mouse_x,
  input  logic [9:0] mouse_y,
  input  logic       mouse_left,
  input  logic       level_cleared,
  input  logic [1:0] cleared_id,
  output logic       mouseInLevel1,
  output logic       mouseInLevel2,
  output logic       mouseInLevel3,
  output logic       level_valid,
  output logic [1:0] level_id,
  input  logic       level_ack
);

  logic        w_btn_db;
  logic        w_btn_rise;
  logic        w_btn_fall;
  logic [3:1]  w_hit;
  logic [3:1]  w_unlocked;
  logic [3:1]  r_hover;
  logic [1:0]  r_sel;
  logic        w_hover_sel;
  logic [1:0]  w_hover_id;
  logic        r_level_valid;
  logic [1:0]  r_level_id;
  menu_state_t r_state;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .i_btn_raw  (mouse_left),
    .o_btn_db   (w_btn_db),
    .o_btn_rise (w_btn_rise),
    .o_btn_fall (w_btn_fall)
  );

  for (genvar k = 1; k <= 3; k++) begin : g_hit
    assign w_hit[k] = in_button(mouse_x, mouse_y, 2'(k));
  end

`ifdef MENU_LEVEL_LOCK_EN
  logic [3:1] r_unlocked;

  // Clearing level n opens level n+1; level 3 has no successor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_unlocked <= 3'b001;
    end else if (level_cleared) begin
      if (cleared_id == LVL_1) r_unlocked[2] <= 1'b1;
      if (cleared_id == LVL_2) r_unlocked[3] <= 1'b1;
    end
  end

  assign w_unlocked = r_unlocked;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = level_cleared ^ (^cleared_id);
  assign w_unlocked   = 3'b111;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hover <= 3'b000;
    end else begin
      r_hover <= w_hit & w_unlocked & {3{in_menu}};
    end
  end

  always_comb begin
    w_hover_sel = 1'b0;
    case (r_sel)
      LVL_1:   w_hover_sel = r_hover[1];
      LVL_2:   w_hover_sel = r_hover[2];
      LVL_3:   w_hover_sel = r_hover[3];
      default: w_hover_sel = 1'b0;
    endcase
  end

  // Boxes are disjoint, so at most one hover bit is ever set.
  always_comb begin
    w_hover_id = LVL_NONE;
    if (r_hover[1]) w_hover_id = LVL_1;
    if (r_hover[2]) w_hover_id = LVL_2;
    if (r_hover[3]) w_hover_id = LVL_3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sel         <= LVL_NONE;
      r_level_valid <= 1'b0;
      r_level_id    <= LVL_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel <= LVL_NONE;
          if (in_menu) r_state <= ST_ARM;
        end
        ST_ARM: begin
          // Swallow whatever press was in progress when the menu opened.
          if (!in_menu)       r_state <= ST_IDLE;
          else if (!w_btn_db) r_state <= ST_READY;
        end
        ST_READY: begin
          if (!in_menu) begin
            r_state <= ST_IDLE;
          end else if (w_btn_rise && (w_hover_id != LVL_NONE)) begin
            r_sel   <= w_hover_id;
            r_state <= ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (!in_menu) begin
            r_state <= ST_IDLE;
          end else if (w_btn_fall) begin
            if (w_hover_sel) begin
              r_state       <= ST_REQ;
              r_level_valid <= 1'b1;
              r_level_id    <= r_sel;
            end else begin
              r_state <= ST_READY;
            end
          end
        end
        ST_REQ: begin
          if (level_ack) begin
            r_state       <= ST_IDLE;
            r_level_valid <= 1'b0;
            r_level_id    <= LVL_NONE;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_level_valid <= 1'b0;
          r_level_id    <= LVL_NONE;
        end
      endcase
    end
  end

  assign mouseInLevel1 = r_hover[1];
  assign mouseInLevel2 = r_hover[2];
  assign mouseInLevel3 = r_hover[3];
  assign level_valid   = r_level_valid;
  assign level_id      = r_level_id;

endmodule
`default_nettype wire

// File: tb/tb_menu_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_menu_input_ctrl
// Purpose  : Directed self-checking bench for menu_input_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_menu_input_ctrl;
  import menu_pkg::*;

  localparam int C_DB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_menu = 1'b0;
  logic [9:0] mouse_x = '0;
  logic [9:0] mouse_y = '0;
  logic       mouse_left = 1'b0;
  logic       level_cleared = 1'b0;
  logic [1:0] cleared_id = '0;
  logic       mouseInLevel1, mouseInLevel2, mouseInLevel3;
  logic       level_valid;
  logic [1:0] level_id;
  logic       level_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int req_count = 0;
  logic r_valid_d = 1'b0;
  logic db_seen = 1'b0;

  menu_input_ctrl #(.DEBOUNCE_CYCLES(C_DB), .DB_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_menu       (in_menu),
    .mouse_x       (mouse_x),
    .mouse_y       (mouse_y),
    .mouse_left    (mouse_left),
    .level_cleared (level_cleared),
    .cleared_id    (cleared_id),
    .mouseInLevel1 (mouseInLevel1),
    .mouseInLevel2 (mouseInLevel2),
    .mouseInLevel3 (mouseInLevel3),
    .level_valid   (level_valid),
    .level_id      (level_id),
    .level_ack     (level_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    r_valid_d <= level_valid;
    if (level_valid && !r_valid_d) req_count <= req_count + 1;
    if (dut.u_debounce.r_btn_db) db_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic move(input int x, input int y);
    mouse_x = 10'(x);
    mouse_y = 10'(y);
  endtask

  task automatic click();
    mouse_left = 1'b1;
    tick(C_DB + 3);
    mouse_left = 1'b0;
    tick(C_DB + 2);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (level_valid) break;
      tick(1);
    end
    check(tag, 32'(level_valid), 32'd1);
  endtask

  task automatic pulse_cleared(input logic [1:0] id);
    level_cleared = 1'b1;
    cleared_id    = id;
    tick(1);
    level_cleared = 1'b0;
    cleared_id    = 2'd0;
  endtask

  initial begin
    // Reset with pointer on button 1 and menu shown.
    in_menu = 1'b1;
    move(200, 100);
    #2 rst = 1'b1;
    tick(3);
    check("rst_hover", 32'({mouseInLevel1, mouseInLevel2, mouseInLevel3}), 32'd0);
    check("rst_valid", 32'({level_valid, level_id}), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    check("rst_db", 32'(dut.u_debounce.r_btn_db), 32'd0);
    rst = 1'b0;
    tick(1);
    check("hover1_after_rst", 32'({mouseInLevel1, mouseInLevel2, mouseInLevel3}), 32'b100);

    // Hover latency: exactly one cycle.
    move(200, 230);
    check("hover_lat_0", 32'(mouseInLevel2), 32'd0);
    tick(1);
    check("hover_lat_1", 32'({mouseInLevel1, mouseInLevel2, mouseInLevel3}), 32'b010);
    move(200, 100);
    tick(1);

    // Enter menu with button already held: the held press must not select.
    in_menu = 1'b0;
    tick(2);
    mouse_left = 1'b1;
    tick(C_DB + 1);
    check("db_lat_pre", 32'(dut.u_debounce.r_btn_db), 32'd0);
    tick(1);
    check("db_lat", 32'(dut.u_debounce.r_btn_db), 32'd1);
    tick(2);
    in_menu = 1'b1;
    tick(3);
    check("arm_hold", 32'(dut.r_state), 32'(ST_ARM));
    mouse_left = 1'b0;
    tick(C_DB + 2);
    tick(2);
    check("ready", 32'(dut.r_state), 32'(ST_READY));
    check("no_req_held", 32'(req_count), 32'd0);
    click();
    check("req_lat_0", 32'(level_valid), 32'd0);
    tick(1);
    check("req1", 32'({level_valid, level_id}), 32'b101);
    level_ack = 1'b1;
    tick(1);
    level_ack = 1'b0;
    check("ack1_drop", 32'({level_valid, level_id}), 32'd0);
    check("req_count1", 32'(req_count), 32'd1);

    // Drag-off cancels the click.
    pulse_cleared(2'd1);
    move(300, 220);
    tick(3);
    check("hover2", 32'(mouseInLevel2), 32'd1);
    mouse_left = 1'b1;
    tick(C_DB + 3);
    check("press2", 32'(dut.r_state), 32'(ST_PRESS));
    move(300, 300);
    tick(2);
    mouse_left = 1'b0;
    tick(C_DB + 5);
    check("drag_valid", 32'(level_valid), 32'd0);
    check("drag_state", 32'(dut.r_state), 32'(ST_READY));

    // Short glitches never reach the debounced level.
    move(300, 220);
    tick(2);
    db_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mouse_left = 1'b1;
      tick(3);
      mouse_left = 1'b0;
      tick(3);
    end
    tick(C_DB + 4);
    check("glitch_db", 32'(db_seen), 32'd0);
    check("glitch_valid", 32'(level_valid), 32'd0);

    // Stray ack outside REQ, then level 2 with a delayed ack.
    level_ack = 1'b1;
    tick(1);
    level_ack = 1'b0;
    check("stray_ack", 32'(dut.r_state), 32'(ST_READY));
    click();
    wait_valid("req2_seen");
    for (int i = 0; i < 10; i++) begin
      check("req2_hold", 32'({level_valid, level_id}), 32'b110);
      tick(1);
    end
    level_ack = 1'b1;
    tick(1);
    level_ack = 1'b0;
    check("ack2_drop", 32'({level_valid, level_id}), 32'd0);

    // Button 3: locked until level 2 is cleared when locking is built in.
    move(300, 340);
    tick(3);
`ifdef MENU_LEVEL_LOCK_EN
    check("lock_hover3", 32'(mouseInLevel3), 32'd0);
    click();
    tick(5);
    check("lock_no_req", 32'(level_valid), 32'd0);
    pulse_cleared(2'd3);
    tick(1);
    check("clear3_noeffect", 32'(mouseInLevel3), 32'd0);
    pulse_cleared(2'd2);
    tick(1);
`else
    pulse_cleared(2'd2);
    tick(1);
`endif
    check("hover3", 32'({mouseInLevel1, mouseInLevel2, mouseInLevel3}), 32'b001);
    click();
    wait_valid("req3_seen");
    check("req3", 32'({level_valid, level_id}), 32'b111);
    level_ack = 1'b1;
    tick(1);
    level_ack = 1'b0;
    tick(2);

    // Leaving the menu mid-press aborts.
    move(300, 220);
    tick(2);
    mouse_left = 1'b1;
    tick(C_DB + 3);
    check("press_leave", 32'(dut.r_state), 32'(ST_PRESS));
    in_menu = 1'b0;
    tick(1);
    check("leave_idle", 32'(dut.r_state), 32'(ST_IDLE));
    mouse_left = 1'b0;
    tick(C_DB + 4);
    check("leave_no_req", 32'(level_valid), 32'd0);
    in_menu = 1'b1;
    tick(2);

    // Asynchronous reset clears a pending request between edges.
    click();
    wait_valid("req_before_rst");
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'({level_valid, level_id}), 32'd0);
    check("async_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    tick(1);
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
